// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word-addressed memory plus MMIO slave on the CPU's shared bus, with a streaming program loader.
// Define TEXT_PROTECT_EN to make words 0..TEXT_WORDS-1 read-only to CPU data writes.
module mem_bus_responder #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int TEXT_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemEn,
  input  logic        MemWen,
  input  logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        cpu_hold,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        err
);
`ifdef TEXT_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  typedef enum logic {RUN, LOAD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, mem_wa;
  logic [31:0] cnt_q, cnt_d, rdata, mem_wd;
  logic [15:0] io_out_q, io_out_d;
  logic err_q, err_d, ld_done_q, ld_done_d;
  logic run, rd, wr, in_mem, a_out, a_in, a_cnt, bad, prot_hit, accept, mem_we;
  logic [31:0] mem [DEPTH];

  assign run      = state_q == RUN;
  assign rd       = run & ~(MemEn & MemWen);
  assign wr       = run & MemEn & MemWen;
  assign in_mem   = addr_bus < 32'(DEPTH);
  assign a_out    = addr_bus == 32'hFFFF_FF00;
  assign a_in     = addr_bus == 32'hFFFF_FF01;
  assign a_cnt    = addr_bus == 32'hFFFF_FF02;
  assign bad      = ~(in_mem | a_out | a_in | a_cnt);
  assign prot_hit = PROT & wr & in_mem & (addr_bus < 32'(TEXT_WORDS));
  assign accept   = ~run & ld_valid;
  assign mem_we   = run ? wr & in_mem & ~prot_hit : accept;
  assign mem_wa   = run ? addr_bus[AW-1:0] : ptr_q;
  assign mem_wd   = run ? data_bus : ld_data;
  assign rdata    = in_mem ? mem[addr_bus[AW-1:0]] : a_out ? {16'd0, io_out_q} :
                    a_in ? {16'd0, io_in} : a_cnt ? cnt_q : '0;
  // zero-latency read; the bus is released for writes and for the whole load
  assign data_bus = rd ? rdata : 'z;
  assign ld_ready = ~run;
  assign cpu_hold = ~run;
  assign ld_done  = ld_done_q;
  assign io_out   = io_out_q;
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    io_out_d  = io_out_q;
    err_d     = err_q;
    ld_done_d = 1'b0;
    if (run) begin
      state_d  = ld_start ? LOAD : RUN;
      ptr_d    = ld_start ? '0 : ptr_q;
      cnt_d    = ld_start ? '0 : cnt_q + 32'd1;
      io_out_d = (wr & a_out) ? data_bus[15:0] : io_out_q;
      err_d    = err_q | bad | prot_hit;
    end else if (accept) begin
      ptr_d     = ptr_q + 1'b1;
      ld_done_d = ld_last | (ptr_q == AW'(DEPTH - 1));
      state_d   = ld_done_d ? RUN : LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      cnt_q     <= '0;
      io_out_q  <= '0;
      err_q     <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      io_out_q  <= io_out_d;
      err_q     <= err_d;
      ld_done_q <= ld_done_d;
    end

  // contents deliberately survive reset
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed stimulus pushes expectations into a scoreboard queue; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_bus_responder;
`ifdef TEXT_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int D = 0, IO = 1, ER = 2, CH = 3, DONE = 4, RDY = 5;
  logic clk = 0, reset = 1, MemEn = 0, MemWen = 0, ld_start = 0, ld_valid = 0, ld_last = 0, drv = 0;
  logic [31:0] addr_bus = 0, wdat = 0, ld_data = 0;
  logic [15:0] io_in = 16'h1234;
  wire  [31:0] data_bus;
  logic ld_ready, ld_done, cpu_hold, err;
  logic [15:0] io_out;
  int cyc = 0, checks = 0, errors = 0, tid = 0;
  typedef struct {int cyc; int sel; logic [31:0] exp; int id;} item_t;
  item_t sb[$];
  item_t it;
  logic [31:0] act;

  assign data_bus = drv ? wdat : 'z;

  mem_bus_responder dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemWen(MemWen), .addr_bus(addr_bus), .data_bus(data_bus),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .cpu_hold(cpu_hold), .io_in(io_in), .io_out(io_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    return sel == D ? data_bus : sel == IO ? {16'd0, io_out} : sel == ER ? {31'd0, err} :
           sel == CH ? {31'd0, cpu_hold} : sel == DONE ? {31'd0, ld_done} : {31'd0, ld_ready};
  endfunction

  function automatic string nm(input int sel);
    return sel == D ? "data_bus" : sel == IO ? "io_out" : sel == ER ? "err" :
           sel == CH ? "cpu_hold" : sel == DONE ? "ld_done" : "ld_ready";
  endfunction

  always @(negedge clk)
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      act = probe(it.sel);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL test%0d %s cycle %0d: got %h expected %h", it.id, nm(it.sel), it.cyc, act, it.exp);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int sel, input logic [31:0] v);
    sb.push_back('{cyc, sel, v, tid});
  endtask

  task automatic bus(input logic en, input logic wen, input logic [31:0] a, input logic d, input logic [31:0] w);
    MemEn = en; MemWen = wen; addr_bus = a; drv = d; wdat = w;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus(1'b0, 1'b0, a, 1'b0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b1, 1'b0, a, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w);
    bus(1'b1, 1'b1, a, 1'b1, w);
  endtask

  initial begin
    tick();
    want(CH, 0); want(RDY, 0); want(DONE, 0); want(ER, 0); want(IO, 0);
    tick(); reset = 0;
    tid = 1;
    tick(); ld_start = 1; fetch(0);
    tick(); ld_start = 0; ld_valid = 1; ld_data = 32'h1111_1111;
    bus(1'b1, 1'b0, 32'hFFFF_FF01, 1'b1, '0);
    want(CH, 1); want(RDY, 1); want(D, 0);
    tick(); ld_data = 32'h2222_2222; wr(32'hFFFF_FF00, 32'h0000_FFFF);
    tick(); ld_data = 32'h3333_3333; ld_last = 1; bus(1'b1, 1'b0, 32'h0000_1000, 1'b1, '0);
    want(IO, 0); want(D, 0);
    tick(); ld_valid = 0; ld_last = 0; rd(32'hFFFF_FF02);
    want(D, 0); want(DONE, 1); want(CH, 0); want(RDY, 0); want(ER, 0);
    tick(); fetch(0); want(D, 32'h1111_1111); want(DONE, 0);
    tick(); fetch(1); want(D, 32'h2222_2222);
    tick(); fetch(2); want(D, 32'h3333_3333);
    for (int i = 0; i < 6; i++) begin tick(); fetch(0); end
    tid = 4;
    tick(); rd(32'hFFFF_FF02); want(D, 32'd10);
    tick(); force dut.cnt_q = 32'hFFFF_FFFF; want(D, 32'hFFFF_FFFF);
    #6 release dut.cnt_q;
    tick(); want(D, 32'd0);
    tid = 2;
    tick(); wr(5, 32'hDEAD_BEEF); want(D, 32'hDEAD_BEEF);
    tick(); wr(32'hFFFF_FF01, 32'h0); want(D, 0);
    tick(); rd(5); want(D, 32'hDEAD_BEEF);
    tid = 3;
    tick(); wr(32'hFFFF_FF00, 32'h0000_A5A5);
    tick(); rd(32'hFFFF_FF00); want(D, 32'h0000_A5A5); want(IO, 16'hA5A5);
    tick(); rd(32'hFFFF_FF01); want(D, 32'h0000_1234); want(ER, 0);
    tid = 5;
    tick(); rd(32'h0000_03FF);
    tick(); rd(32'h0000_1000); want(D, 0); want(ER, 0);
    tick(); fetch(0); want(ER, 1);
    for (int i = 0; i < 3; i++) begin tick(); fetch(0); end
    want(ER, 1);
    tid = 6;
    tick(); ld_start = 1;
    tick(); ld_start = 0; ld_valid = 1; ld_data = 32'hAAAA_0000; want(CH, 1);
    tick(); ld_data = 32'hAAAA_0001;
    tick(); ld_valid = 0; reset = 1;
    want(CH, 0); want(RDY, 0); want(DONE, 0); want(ER, 0);
    tick(); reset = 0; want(DONE, 0); want(CH, 0);
    tick(); fetch(0); want(D, 32'hAAAA_0000); want(DONE, 0);
    tick(); fetch(1); want(D, 32'hAAAA_0001);
    tick(); fetch(2); want(D, 32'h3333_3333);
    tid = 7;
    tick(); ld_start = 1; fetch(0);
    for (int i = 0; i < 1024; i++) begin
      tick(); ld_start = 0; ld_valid = 1; ld_data = 32'(i);
      if (i == 1023) begin want(RDY, 1); want(CH, 1); end
    end
    tick(); ld_data = 32'h0000_0BAD; want(DONE, 1); want(RDY, 0); want(CH, 0);
    tick(); ld_valid = 0; fetch(0); want(D, 0); want(DONE, 0);
    tick(); fetch(1023); want(D, 32'd1023);
    tick(); fetch(1); want(D, 32'd1);
    tid = 8;
    tick(); wr(3, 32'hCAFE_F00D);
    tick(); rd(3); want(D, PROT ? 32'd3 : 32'hCAFE_F00D); want(ER, {31'd0, PROT});
    tick(); wr(256, 32'h5A5A_5A5A);
    tick(); rd(256); want(D, 32'h5A5A_5A5A);
    tick(); fetch(0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave end of the CPU's shared addr_bus/data_bus protocol: word-addressed unified instruction/data memory plus a small memory-mapped I/O window.
- Decodes MemEn/MemWen exactly as the CPU encodes them and drives data_bus only when the CPU expects read data.
- Contains a streaming program loader FSM that holds the CPU while filling memory from an external source (UART/host bridge).

Parameters:
- DEPTH, 1024, memory size in 32-bit words; power of two, at least 16.
- AW, 10, memory index width, equal to log2(DEPTH).
- TEXT_WORDS, 256, size of the protected text region (used only with TEXT_PROTECT_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemEn  in  1  from CPU; 0 = instruction fetch, 1 = data access.
- MemWen  in  1  from CPU; qualifies a data access as a write when MemEn=1.
- addr_bus  in  32  word address: PC on fetch, ALU result on data access.
- data_bus  inout  32  shared data bus.
- ld_start  in  1  request a program load.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks the final loader word.
- ld_ready  out  1  loader may present a word.
- ld_done  out  1  one-cycle pulse when a load completes.
- cpu_hold  out  1  keeps the CPU in reset while loading.
- io_in  in  16  switch inputs.
- io_out  out  16  LED register.
- err  out  1  sticky bus error flag.

Behaviour:
- Reset (async) values: FSM=RUN, ld_ready=0, ld_done=0, cpu_hold=0, io_out=0, err=0, cycle counter=0, load pointer=0. Memory array is not cleared; contents survive reset.
- Bus cycle decode (RUN state only):
  - fetch = ~MemEn; read = MemEn & ~MemWen; write = MemEn & MemWen.
  - Responder drives data_bus combinationally during fetch or read; it is high-Z during write and in all LOAD-state cycles.
  - Read data is valid in the same cycle it is requested (zero latency), so the CPU can capture it on the next edge.
- Address map (word addresses):
  - 0..DEPTH-1: memory. Reads are combinational; writes occur at the clock edge with data sampled from data_bus.
  - 0xFFFFFF00: io_out. Read returns {16'd0, io_out}; a write loads io_out <= data_bus[15:0].
  - 0xFFFFFF01: io_in. Read-only; returns {16'd0, io_in}; writes are ignored.
  - 0xFFFFFF02: cycle counter. Read-only; 32-bit, increments once per RUN cycle, wraps 0xFFFFFFFF -> 0, cleared on LOAD entry.
  - Any other address: reads return 0 and writes are dropped; both set err=1. err clears only on reset.
- Loader FSM, states RUN and LOAD:
  - RUN -> LOAD on ld_start=1. Pointer <= 0, counter <= 0, cpu_hold=1 and ld_ready=1 from the next cycle.
  - In LOAD, every cycle with ld_valid & ld_ready writes mem[ptr] <= ld_data, then ptr <= ptr+1.
  - LOAD -> RUN when the accepted word has ld_last=1, or when ptr = DEPTH-1 (memory full; further words are not accepted).
  - On the LOAD -> RUN transition: ld_done=1 for exactly one cycle, and cpu_hold and ld_ready fall in the same cycle ld_done rises.
  - ld_start while already in LOAD is ignored.
  - ld_valid while in RUN is ignored.
  - CPU bus activity during LOAD is ignored: no writes, no err updates.
- Simultaneous events:
  - ld_start and a CPU write in the same RUN cycle: the write completes, then LOAD is entered.
- Reset mid-load: FSM returns to RUN and cpu_hold drops; words already written stay in memory; ld_done is not pulsed.

Optional Feature:
- Macro: TEXT_PROTECT_EN.
- Defined: CPU data writes to addresses 0..TEXT_WORDS-1 are dropped and set err=1. Loader writes are unaffected.
- Undefined: the whole memory is CPU-writable. TEXT_WORDS is unused.

Test Plan:
1. Reset, then ld_start; stream 3 words 0x11111111, 0x22222222, 0x33333333 with ld_last on the third -> ld_done pulses 1 cycle, cpu_hold falls; fetches at addresses 0/1/2 return the three words in order.
2. RUN; write 0xDEADBEEF to address 5, then read address 5 -> data_bus = 0xDEADBEEF; during the write cycle the responder leaves data_bus high-Z.
3. Write 0x0000A5A5 to 0xFFFFFF00 -> io_out = 0xA5A5; set io_in = 0x1234 and read 0xFFFFFF01 -> data_bus = 0x00001234.
4. Read 0xFFFFFF02 twice, 10 cycles apart -> second value = first + 10. Force the counter to 0xFFFFFFFF -> it reads 0 one cycle later.
5. Read address 0x00001000 (DEPTH=1024) -> data_bus = 0 and err=1; err stays set until reset.
6. Assert reset after 2 of 4 load words -> cpu_hold=0, no ld_done pulse, mem[0..1] hold the loaded words. With TEXT_PROTECT_EN defined, a CPU write to address 3 leaves memory unchanged and sets err=1.
